// File: rtl/sbox_arbiter.sv
// sbox_arbiter: time-shares one 4-lane S-box between a 128-bit SubBytes requester and a 32-bit SubWord requester.
// Build option SBOX_ARB_KW_PRIORITY_EN: key expansion always wins ties (default build is round-robin).
module sbox_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sb_req_valid,
    input  logic [127:0] sb_req_data,
    output logic         sb_req_ready,
    output logic         sb_resp_valid,
    output logic [127:0] sb_resp_data,
    input  logic         kw_req_valid,
    input  logic [31:0]  kw_req_data,
    output logic         kw_req_ready,
    output logic         kw_resp_valid,
    output logic [31:0]  kw_resp_data,
    output logic [7:0]   sbox_addr1,
    output logic [7:0]   sbox_addr2,
    output logic [7:0]   sbox_addr3,
    output logic [7:0]   sbox_addr4,
    input  logic [31:0]  sbox_data,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        SB_RUN,
        KW_RUN,
        SB_DONE,
        KW_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    word_cnt;
    logic [127:0]  sb_data_q;
    logic [31:0]   kw_data_q;
    logic [95:0]   sb_acc;
    logic [31:0]   cur_word;
    logic          grant_sb;
    logic          grant_kw;
    logic          sb_fire;
    logic          kw_fire;

`ifdef SBOX_ARB_KW_PRIORITY_EN
    assign grant_kw = kw_req_valid;
`else
    // pref = 1 hands a tie to SubBytes, pref = 0 to key expansion
    logic pref;
    assign grant_kw = kw_req_valid && (!sb_req_valid || !pref);
`endif
    assign grant_sb = sb_req_valid && !grant_kw;

    assign sb_fire = sb_req_valid && sb_req_ready;
    assign kw_fire = kw_req_valid && kw_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is gated by rst_n so nothing can look accepted while reset is held
    always_comb begin
        state_next    = state;
        sb_req_ready  = 1'b0;
        kw_req_ready  = 1'b0;
        sb_resp_valid = 1'b0;
        kw_resp_valid = 1'b0;
        busy          = 1'b1;
        cur_word      = 32'd0;
        case (state)
            IDLE: begin
                busy         = 1'b0;
                sb_req_ready = rst_n && grant_sb;
                kw_req_ready = rst_n && grant_kw;
                if (grant_sb) begin
                    state_next = SB_RUN;
                end else if (grant_kw) begin
                    state_next = KW_RUN;
                end
            end
            SB_RUN: begin
                case (word_cnt)
                    2'd0:    cur_word = sb_data_q[127:96];
                    2'd1:    cur_word = sb_data_q[95:64];
                    2'd2:    cur_word = sb_data_q[63:32];
                    default: cur_word = sb_data_q[31:0];
                endcase
                if (word_cnt == 2'd3) begin
                    state_next = SB_DONE;
                end
            end
            KW_RUN: begin
                cur_word   = kw_data_q;
                state_next = KW_DONE;
            end
            SB_DONE: begin
                sb_resp_valid = 1'b1;
                state_next    = IDLE;
            end
            KW_DONE: begin
                kw_resp_valid = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign {sbox_addr1, sbox_addr2, sbox_addr3, sbox_addr4} = cur_word;

    // Words 0..2 collect in sb_acc so sb_resp_data changes only when the full block is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt     <= 2'd0;
            sb_data_q    <= 128'd0;
            kw_data_q    <= 32'd0;
            sb_acc       <= 96'd0;
            sb_resp_data <= 128'd0;
            kw_resp_data <= 32'd0;
`ifndef SBOX_ARB_KW_PRIORITY_EN
            pref         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    word_cnt <= 2'd0;
                    if (sb_fire) begin
                        sb_data_q <= sb_req_data;
                    end
                    if (kw_fire) begin
                        kw_data_q <= kw_req_data;
                    end
`ifndef SBOX_ARB_KW_PRIORITY_EN
                    if (sb_fire) begin
                        pref <= 1'b0;
                    end else if (kw_fire) begin
                        pref <= 1'b1;
                    end
`endif
                end
                SB_RUN: begin
                    word_cnt <= word_cnt + 2'd1;
                    case (word_cnt)
                        2'd0:    sb_acc[95:64] <= sbox_data;
                        2'd1:    sb_acc[63:32] <= sbox_data;
                        2'd2:    sb_acc[31:0]  <= sbox_data;
                        default: sb_resp_data  <= {sb_acc, sbox_data};
                    endcase
                end
                KW_RUN: begin
                    kw_resp_data <= sbox_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// tb_sbox_arbiter: directed scoreboard bench for sbox_arbiter with a behavioural AES S-box on the shared port.
// Honours SBOX_ARB_KW_PRIORITY_EN for the expected tie-break order.
module tb_sbox_arbiter;

    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SBOX_ARB_KW_PRIORITY_EN
    localparam logic [2:0] TIE_ORDER = 3'b000;
`else
    localparam logic [2:0] TIE_ORDER = 3'b010;
`endif

    logic         clk;
    logic         rst_n;
    logic         sb_req_valid;
    logic [127:0] sb_req_data;
    logic         sb_req_ready;
    logic         sb_resp_valid;
    logic [127:0] sb_resp_data;
    logic         kw_req_valid;
    logic [31:0]  kw_req_data;
    logic         kw_req_ready;
    logic         kw_resp_valid;
    logic [31:0]  kw_resp_data;
    logic [7:0]   sbox_addr1;
    logic [7:0]   sbox_addr2;
    logic [7:0]   sbox_addr3;
    logic [7:0]   sbox_addr4;
    logic [31:0]  sbox_data;
    logic         busy;
    logic [31:0]  addrs;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;

    logic [127:0] sbQ[$];
    logic [31:0]  kwQ[$];
    int           sbHs[$];
    int           kwHs[$];
    logic [127:0] monSbExp;
    logic [31:0]  monKwExp;
    int           monSbHs;
    int           monKwHs;

    logic [127:0] sbVec[3];
    logic [127:0] sbExp[3];
    logic [31:0]  kwVec[3];
    logic [31:0]  kwExp[3];
    int           sbIdx;
    int           kwIdx;
    int           hsEdge;
    int           hsEdge2;
    int           prevEdge;
    int           gEdge;
    logic         got;
    logic         gotSb;

    sbox_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sb_req_valid  (sb_req_valid),
        .sb_req_data   (sb_req_data),
        .sb_req_ready  (sb_req_ready),
        .sb_resp_valid (sb_resp_valid),
        .sb_resp_data  (sb_resp_data),
        .kw_req_valid  (kw_req_valid),
        .kw_req_data   (kw_req_data),
        .kw_req_ready  (kw_req_ready),
        .kw_resp_valid (kw_resp_valid),
        .kw_resp_data  (kw_resp_data),
        .sbox_addr1    (sbox_addr1),
        .sbox_addr2    (sbox_addr2),
        .sbox_addr3    (sbox_addr3),
        .sbox_addr4    (sbox_addr4),
        .sbox_data     (sbox_data),
        .busy          (busy)
    );

    function automatic logic [7:0] sbLookup(input logic [7:0] a);
        int idx;
        idx = 2047 - 8 * int'(a);
        return SBOX_ROM[idx -: 8];
    endfunction

    assign sbox_data = {sbLookup(sbox_addr1), sbLookup(sbox_addr2), sbLookup(sbox_addr3), sbLookup(sbox_addr4)};
    assign addrs = {sbox_addr1, sbox_addr2, sbox_addr3, sbox_addr4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: logs handshakes, pops the scoreboard on every response pulse
    always @(negedge clk) begin
        if (sb_req_valid && sb_req_ready) sbHs.push_back(edgeCnt + 1);
        if (kw_req_valid && kw_req_ready) kwHs.push_back(edgeCnt + 1);
        if (sb_resp_valid) begin
            if (sbQ.size() == 0 || sbHs.size() == 0) begin
                checkOutput("sb_unexpected_resp", 128'd1, 128'd0);
            end else begin
                monSbExp = sbQ.pop_front();
                monSbHs  = sbHs.pop_front();
                checkOutput("sb_resp_data", sb_resp_data, monSbExp);
                checkOutput("sb_latency", 128'(edgeCnt + 1 - monSbHs), 128'd5);
            end
        end
        if (kw_resp_valid) begin
            if (kwQ.size() == 0 || kwHs.size() == 0) begin
                checkOutput("kw_unexpected_resp", 128'd1, 128'd0);
            end else begin
                monKwExp = kwQ.pop_front();
                monKwHs  = kwHs.pop_front();
                checkOutput("kw_resp_data", 128'(kw_resp_data), 128'(monKwExp));
                checkOutput("kw_latency", 128'(edgeCnt + 1 - monKwHs), 128'd2);
            end
        end
        if (!busy) checkOutput("idle_addr_zero", 128'(addrs), 128'd0);
    end

    // Issue one request (caller is at posedge+1), wait for its handshake, then drop valid
    task automatic applyStimulus(input logic isSb, input logic [127:0] data, input logic [127:0] expResp,
                                 output int hsAt);
        bit seen;
        seen = 1'b0;
        hsAt = -1;
        if (isSb) begin
            sbQ.push_back(expResp);
            sb_req_data  = data;
            sb_req_valid = 1'b1;
        end else begin
            kwQ.push_back(expResp[31:0]);
            kw_req_data  = data[31:0];
            kw_req_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (isSb ? sb_req_ready : kw_req_ready) begin
                seen = 1'b1;
                hsAt = edgeCnt + 1;
            end
        end
        @(posedge clk);
        #1;
        if (isSb) sb_req_valid = 1'b0;
        else kw_req_valid = 1'b0;
        if (!seen) begin
            checkOutput("handshake_timeout", 128'd0, 128'd1);
            if (isSb) void'(sbQ.pop_back());
            else void'(kwQ.pop_back());
        end
    endtask

    task automatic checkSbAddrs(input logic [127:0] data);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("sb_run_addr", 128'(addrs), 128'(data[127 - 32 * k -: 32]));
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && (sbQ.size() != 0 || kwQ.size() != 0 || busy); i++) @(negedge clk);
        if (sbQ.size() != 0 || kwQ.size() != 0) checkOutput("drain_timeout", 128'd1, 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sbVec[0] = 128'd0;
        sbExp[0] = {16{8'h63}};
        sbVec[1] = 128'h53000000_00000000_00000000_00000001;
        sbExp[1] = 128'hED636363_63636363_63636363_6363637C;
        sbVec[2] = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        sbExp[2] = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
        kwVec[0] = 32'h00010203;
        kwExp[0] = 32'h637C777B;
        kwVec[1] = 32'h53530001;
        kwExp[1] = 32'hEDED637C;
        kwVec[2] = 32'h10203040;
        kwExp[2] = 32'hCAB70409;

        // Reset with both requesters pushing: nothing may be granted
        rst_n        = 1'b0;
        sb_req_valid = 1'b1;
        kw_req_valid = 1'b1;
        sb_req_data  = 128'd0;
        kw_req_data  = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_sb_ready", 128'(sb_req_ready), 128'd0);
        checkOutput("reset_kw_ready", 128'(kw_req_ready), 128'd0);
        checkOutput("reset_resp_valid", 128'({sb_resp_valid, kw_resp_valid}), 128'd0);
        checkOutput("reset_sb_data", sb_resp_data, 128'd0);
        checkOutput("reset_kw_data", 128'(kw_resp_data), 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        sb_req_valid = 1'b0;
        kw_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, sbVec[0], sbExp[0], hsEdge);
        checkSbAddrs(sbVec[0]);
        waitDrain();

        applyStimulus(1'b0, 128'(kwVec[0]), 128'(kwExp[0]), hsEdge);
        @(negedge clk);
        checkOutput("kw_run_addr", 128'(addrs), 128'(kwVec[0]));
        waitDrain();

        applyStimulus(1'b1, sbVec[1], sbExp[1], hsEdge);
        checkSbAddrs(sbVec[1]);
        waitDrain();

        applyStimulus(1'b1, sbVec[2], sbExp[2], hsEdge);
        checkSbAddrs(sbVec[2]);
        waitDrain();

        // Back-to-back SubBytes: second accept lands exactly 6 edges after the first
        applyStimulus(1'b1, {4{32'h53530001}}, {4{32'hEDED637C}}, hsEdge);
        applyStimulus(1'b1, {4{32'h10203040}}, {4{32'hCAB70409}}, hsEdge2);
        checkOutput("sb_throughput", 128'(hsEdge2 - hsEdge), 128'd6);
        waitDrain();

        // Three ties from a fresh reset; each winner re-requests immediately
        applyReset();
        sbIdx        = 0;
        kwIdx        = 0;
        prevEdge     = 0;
        sb_req_data  = sbVec[0];
        kw_req_data  = kwVec[0];
        sb_req_valid = 1'b1;
        kw_req_valid = 1'b1;
        for (int g = 0; g < 3; g++) begin
            if (TIE_ORDER[g]) sbQ.push_back(sbExp[sbIdx]);
            else kwQ.push_back(kwExp[kwIdx]);
            got   = 1'b0;
            gotSb = 1'b0;
            gEdge = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (sb_req_valid && sb_req_ready) begin
                    got   = 1'b1;
                    gotSb = 1'b1;
                    gEdge = edgeCnt + 1;
                end else if (kw_req_valid && kw_req_ready) begin
                    got   = 1'b1;
                    gotSb = 1'b0;
                    gEdge = edgeCnt + 1;
                end
            end
            checkOutput("tie_grant_seen", 128'(got), 128'd1);
            checkOutput("tie_winner", 128'(gotSb), 128'(TIE_ORDER[g]));
            if (g > 0) checkOutput("tie_gap", 128'(gEdge - prevEdge), TIE_ORDER[g - 1] ? 128'd6 : 128'd3);
            prevEdge = gEdge;
            @(posedge clk);
            #1;
            if (gotSb) begin
                sbIdx++;
                if (sbIdx < 3) sb_req_data = sbVec[sbIdx];
            end else begin
                kwIdx++;
                if (kwIdx < 3) kw_req_data = kwVec[kwIdx];
            end
        end
        sb_req_valid = 1'b0;
        kw_req_valid = 1'b0;
        waitDrain();

        // Abort a SubBytes operation while its word counter is 2
        applyStimulus(1'b1, 128'h00010203_10203040_53530001_00000000, {4{32'h0}}, hsEdge);
        repeat (3) @(negedge clk);
        checkOutput("abort_addr_word2", 128'(addrs), 128'h53530001);
        #1;
        rst_n = 1'b0;
        void'(sbQ.pop_back());
        if (sbHs.size() != 0) void'(sbHs.pop_back());
        @(negedge clk);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_resp_valid", 128'(sb_resp_valid), 128'd0);
        checkOutput("abort_addr", 128'(addrs), 128'd0);
        checkOutput("abort_sb_data", sb_resp_data, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(1'b0, 128'(kwVec[2]), 128'(kwExp[2]), hsEdge);
        waitDrain();
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sbox_arbiter.md
SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have ports sb_req_valid (input, 1), sb_req_data (input, 128), and sb_req_ready (output, 1): the SubBytes state request.
REQ-004 SHALL have ports sb_resp_valid (output, 1) and sb_resp_data (output, 128): the SubBytes result.
REQ-005 SHALL have ports kw_req_valid (input, 1), kw_req_data (input, 32), and kw_req_ready (output, 1): the key-expansion SubWord request.
REQ-006 SHALL have ports kw_resp_valid (output, 1) and kw_resp_data (output, 32): the SubWord result.
REQ-007 SHALL have ports sbox_addr1..sbox_addr4 (output, 8 each): the four combinational S-box read addresses.
REQ-008 SHALL have port sbox_data, input, 32 bits: S-box result {S(addr1),S(addr2),S(addr3),S(addr4)}, valid in the same cycle.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, SB_RUN, KW_RUN, SB_DONE, KW_DONE.
REQ-011 SHALL assert request ready only in IDLE, and only for the arbitration winner; handshake = valid && ready on a rising edge.
REQ-012 In IDLE with a single valid requester, that requester SHALL win.
REQ-013 On a tie, the winner SHALL follow the pref flag (0 = KW, 1 = SB); pref SHALL flip to the other requester after every accepted request.
REQ-014 On handshake, input data SHALL be latched, and state SHALL go to SB_RUN (word counter = 0) or KW_RUN.
REQ-015 In SB_RUN, word k (k = 0..3) SHALL be bits [127-32k -: 32]; the MSB byte drives sbox_addr1 and the LSB byte drives sbox_addr4.
REQ-016 In SB_RUN, sbox_data SHALL be captured into result word k each cycle; the counter increments and, after k = 3, the state goes to SB_DONE.
REQ-017 In KW_RUN, the latched word SHALL drive the addresses, sbox_data SHALL be captured, and the state goes to KW_DONE.
REQ-018 SB_DONE/KW_DONE SHALL assert the matching resp_valid for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-019 Latency: SB handshake at edge T gives sb_resp_valid in cycle T+5; KW handshake at T gives kw_resp_valid in cycle T+2.
REQ-020 resp_data SHALL hold its last value until the next response of the same requester.
REQ-021 sbox_addr1..4 SHALL be 0 outside the RUN states.
REQ-022 Requests arriving while busy SHALL be held by the requester (ready low); none SHALL be dropped or reordered.
REQ-023 A new request SHALL be acceptable in the IDLE cycle immediately after DONE; the maximum SB throughput is one request per 6 cycles.

Reset
REQ-024 On rst_n low: state = IDLE, counter = 0, pref = 0.
REQ-025 On rst_n low, all resp_valid and ready outputs SHALL be 0, and all resp_data and addresses SHALL be 0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no response pulse; the first request after release SHALL be handled normally.

Configuration
REQ-027 Macro SBOX_ARB_KW_PRIORITY_EN defined: the KW requester SHALL always win ties and pref SHALL be unused.
REQ-028 Macro SBOX_ARB_KW_PRIORITY_EN undefined: round-robin per REQ-013.

Verification
REQ-029 SB request with data 0 -> sb_resp_data = 0x6363...63 (16 bytes), resp_valid at T+5, addresses observed 0x00 for 4 cycles.
REQ-030 KW request with data 0x00010203 -> kw_resp_data = 0x637C777B at T+2; SB ports stay idle.
REQ-031 SB and KW valid together after reset -> KW granted first (pref = 0), SB granted in the IDLE cycle after kw_resp_valid; third tie -> KW.
REQ-032 SB request with data 0x53000000_00000000_00000000_00000001 -> result 0xED636363_63636363_63636363_6363637C.
REQ-033 rst_n low during SB_RUN counter = 2 -> no sb_resp_valid, busy = 0; the next KW request completes in 2 cycles.
REQ-034 With SBOX_ARB_KW_PRIORITY_EN defined, three back-to-back ties -> KW wins all three arbitrations.
